mem_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 15 +
 rtl/elem_ram.sv | 24 ++
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory-access stage.
package mem_pkg;

    localparam int DEF_MEMO_LINES = 64;
    localparam int DEF_VECT_SIZE  = 8;
    localparam int DEF_ELEM_SIZE  = 8;

    typedef logic [DEF_ELEM_SIZE*DEF_VECT_SIZE-1:0] vec_t;

    typedef enum logic {
        IDLE,
        VBUSY
    } state_t;

endpackage

// File: rtl/elem_ram.sv
// Single-port element memory: combinational read, write on the clock edge.
module elem_ram #(
    parameter int LINES = 64,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(LINES)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [LINES];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: scalar access in one cycle, vector access serialised one element
// per cycle while upstream is stalled; registered result towards MEM/WB.
module mem_stage import mem_pkg::*; #(
    parameter int MEMO_LINES = DEF_MEMO_LINES,
    parameter int VECT_SIZE  = DEF_VECT_SIZE,
    parameter int ELEM_SIZE  = DEF_ELEM_SIZE,
    localparam int ADDR_BITS = $clog2(MEMO_LINES)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           valid_i,
    input  logic [ADDR_BITS-1:0]           addr_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] wdata_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] int_rd_i,
    input  logic                           enableMem_i,
    input  logic                           flagMemRead_i,
    input  logic                           flagMemWrite_i,
    input  logic                           writeResultInt_i,
    input  logic                           writeResultV_i,
    input  logic                           enableReg_i,
    output logic                           stall_o,
    output logic                           valid_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] result_o,
    output logic                           writeResultInt_o,
    output logic                           writeResultV_o,
    output logic                           enableReg_o
);

    localparam int VW       = ELEM_SIZE * VECT_SIZE;
    localparam int CNT_BITS = (VECT_SIZE > 1) ? $clog2(VECT_SIZE) : 1;
    localparam logic [CNT_BITS-1:0] LAST_ELEM = CNT_BITS'(VECT_SIZE - 1);

    state_t                state, stateNext;
    logic [CNT_BITS-1:0]   elemCnt;

    logic [ADDR_BITS-1:0]  opAddr_p1;
    logic [VW-1:0]         opWdata_p1;
    logic [VW-1:0]         opIntRd_p1;
    logic                  opWrite_p1;
    logic                  opWrInt_p1;
    logic                  opWrV_p1;
    logic                  opEnReg_p1;
    logic [VW-1:0]         asm_p1;
    logic [VW-1:0]         asmNext;

    logic                  memOp;
    logic                  isWrite;
    logic                  acceptVec;
    logic                  lastElem;

    logic                  ramWe;
    logic [ADDR_BITS-1:0]  ramAddr;
    logic [ELEM_SIZE-1:0]  ramWdata;
    logic [ELEM_SIZE-1:0]  ramRdata;

    // Write wins when both read and write are flagged.
    assign memOp     = valid_i & enableMem_i & (flagMemRead_i | flagMemWrite_i);
    assign isWrite   = flagMemWrite_i;
    assign acceptVec = (state == IDLE) & memOp & writeResultV_i;
    assign lastElem  = (state == VBUSY) & (elemCnt == LAST_ELEM);

    elem_ram #(
        .LINES (MEMO_LINES),
        .WIDTH (ELEM_SIZE)
    ) uRam (
        .clk_i   (clk_i),
        .we_i    (ramWe),
        .addr_i  (ramAddr),
        .wdata_i (ramWdata),
        .rdata_o (ramRdata)
    );

    always_comb begin
        stateNext = state;
        stall_o   = 1'b0;
        ramAddr   = addr_i;
        ramWe     = memOp & isWrite;
        ramWdata  = wdata_i[ELEM_SIZE-1:0];
        case (state)
            IDLE: begin
                if (acceptVec) begin
                    stall_o   = 1'b1;
                    stateNext = VBUSY;
                end
            end
            VBUSY: begin
                // Address arithmetic wraps naturally in ADDR_BITS.
                ramAddr  = opAddr_p1 + ADDR_BITS'(elemCnt);
                ramWe    = opWrite_p1;
                ramWdata = opWdata_p1[elemCnt*ELEM_SIZE +: ELEM_SIZE];
                stall_o  = ~lastElem;
                if (lastElem) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        asmNext = asm_p1;
        asmNext[elemCnt*ELEM_SIZE +: ELEM_SIZE] = ramRdata;
    end

    // p0 -> p1: control state and MEM/WB outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            elemCnt          <= '0;
            valid_o          <= 1'b0;
            result_o         <= '0;
            writeResultInt_o <= 1'b0;
            writeResultV_o   <= 1'b0;
            enableReg_o      <= 1'b0;
        end else begin
            state   <= stateNext;
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (acceptVec) begin
                        elemCnt <= CNT_BITS'(1);
                    end else if (valid_i) begin
                        valid_o          <= 1'b1;
                        result_o         <= (memOp & ~isWrite) ? VW'(ramRdata) : int_rd_i;
                        writeResultInt_o <= writeResultInt_i;
                        writeResultV_o   <= writeResultV_i;
                        enableReg_o      <= enableReg_i;
                    end
                end
                VBUSY: begin
                    if (lastElem) begin
                        elemCnt          <= '0;
                        valid_o          <= 1'b1;
                        result_o         <= opWrite_p1 ? opIntRd_p1 : asmNext;
                        writeResultInt_o <= opWrInt_p1;
                        writeResultV_o   <= opWrV_p1;
                        enableReg_o      <= opEnReg_p1;
                    end else begin
                        elemCnt <= elemCnt + CNT_BITS'(1);
                    end
                end
                default: elemCnt <= '0;
            endcase
        end
    end

    // p0 -> p1: held vector op and load assembly
    always_ff @(posedge clk_i) begin
        if (acceptVec) begin
            opAddr_p1  <= addr_i;
            opWdata_p1 <= wdata_i;
            opIntRd_p1 <= int_rd_i;
            opWrite_p1 <= isWrite;
            opWrInt_p1 <= writeResultInt_i;
            opWrV_p1   <= writeResultV_i;
            opEnReg_p1 <= enableReg_i;
        end
        if (acceptVec || (state == VBUSY)) begin
            asm_p1 <= asmNext;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of ops with a result scoreboard, plus hand
// sequences for back-to-back issue and reset in the middle of a vector store.
module tb_mem_stage;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       valid_i;
    logic [5:0] addr_i;
    vec_t       wdata_i, int_rd_i;
    logic       enableMem_i, flagMemRead_i, flagMemWrite_i;
    logic       writeResultInt_i, writeResultV_i, enableReg_i;
    logic       stall_o, valid_o;
    vec_t       result_o;
    logic       writeResultInt_o, writeResultV_o, enableReg_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] addr;
        vec_t       wdata;
        vec_t       intRd;
        logic       en, rd, wr, wrInt, wrV, enReg;
        vec_t       expRes;
        int         expStall;
    } opRec;

    typedef struct {
        vec_t res;
        logic wrInt, wrV, enReg;
    } expRec;

    opRec  tbl[$];
    expRec sb[$];

    mem_stage dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .valid_i          (valid_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .int_rd_i         (int_rd_i),
        .enableMem_i      (enableMem_i),
        .flagMemRead_i    (flagMemRead_i),
        .flagMemWrite_i   (flagMemWrite_i),
        .writeResultInt_i (writeResultInt_i),
        .writeResultV_i   (writeResultV_i),
        .enableReg_i      (enableReg_i),
        .stall_o          (stall_o),
        .valid_o          (valid_o),
        .result_o         (result_o),
        .writeResultInt_o (writeResultInt_o),
        .writeResultV_o   (writeResultV_o),
        .enableReg_o      (enableReg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic opRec mk(input logic [5:0] a, input vec_t wd, input vec_t ir,
                                input logic en, input logic rd, input logic wr,
                                input logic wi, input logic wv, input logic er,
                                input vec_t res, input int st);
        opRec o;
        o.addr = a; o.wdata = wd; o.intRd = ir;
        o.en = en; o.rd = rd; o.wr = wr;
        o.wrInt = wi; o.wrV = wv; o.enReg = er;
        o.expRes = res; o.expStall = st;
        return o;
    endfunction

    // Scoreboard: every valid_o pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_ni && valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 result %h expected no output", result_o);
            end else begin
                expRec e;
                e = sb.pop_front();
                chk("sb_result", result_o, e.res);
                chk("sb_wrInt", 64'(writeResultInt_o), 64'(e.wrInt));
                chk("sb_wrV", 64'(writeResultV_o), 64'(e.wrV));
                chk("sb_enReg", 64'(enableReg_o), 64'(e.enReg));
            end
        end
    end

    task automatic applyOp(input opRec o);
        valid_i          = 1'b1;
        addr_i           = o.addr;
        wdata_i          = o.wdata;
        int_rd_i         = o.intRd;
        enableMem_i      = o.en;
        flagMemRead_i    = o.rd;
        flagMemWrite_i   = o.wr;
        writeResultInt_i = o.wrInt;
        writeResultV_i   = o.wrV;
        enableReg_i      = o.enReg;
    endtask

    // Presents an op, follows the stall, and returns just after the edge on
    // which upstream advances (inputs still hold the op at that point).
    task automatic sendOp(input opRec o);
        expRec e;
        int    stallCnt;
        int    guard;
        applyOp(o);
        e.res = o.expRes; e.wrInt = o.wrInt; e.wrV = o.wrV; e.enReg = o.enReg;
        sb.push_back(e);
        stallCnt = 0;
        guard    = 0;
        #1;
        while (stall_o && guard < 64) begin
            stallCnt++;
            guard++;
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", 64'(stallCnt), 64'(o.expStall));
        @(posedge clk);
        #1;
        chk("valid_latency", 64'(valid_o), 64'd1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        valid_i = 1'b0; addr_i = '0; wdata_i = '0; int_rd_i = '0;
        enableMem_i = 1'b0; flagMemRead_i = 1'b0; flagMemWrite_i = 1'b0;
        writeResultInt_i = 1'b0; writeResultV_i = 1'b0; enableReg_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_flags", {61'd0, writeResultInt_o, writeResultV_o, enableReg_o}, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        //        addr wdata                   intRd                   en rd wr wi wv er expRes                  stall
        tbl.push_back(mk(0,  64'h0,                 64'h1122334455667788, 0, 0, 0, 1, 0, 1, 64'h1122334455667788, 0));
        tbl.push_back(mk(5,  64'hA5,                64'hDEAD,             1, 0, 1, 0, 0, 0, 64'hDEAD,             0));
        tbl.push_back(mk(5,  64'h0,                 64'hFFFF,             1, 1, 0, 1, 0, 1, 64'hA5,               0));
        tbl.push_back(mk(7,  64'hFFEEDDCCBBAA9966,  64'h1,                1, 0, 1, 0, 0, 0, 64'h1,                0));
        tbl.push_back(mk(7,  64'h0,                 64'h0,                1, 1, 0, 1, 0, 1, 64'h66,               0));
        tbl.push_back(mk(62, 64'h0807060504030201,  64'h55,               1, 0, 1, 0, 1, 0, 64'h55,               7));
        tbl.push_back(mk(62, 64'h0,                 64'h0,                1, 1, 0, 0, 1, 1, 64'h0807060504030201, 7));
        tbl.push_back(mk(0,  64'h0,                 64'h0,                1, 1, 0, 1, 0, 0, 64'h03,               0));
        tbl.push_back(mk(63, 64'h0,                 64'h0,                1, 1, 0, 1, 0, 0, 64'h02,               0));
        tbl.push_back(mk(5,  64'h0,                 64'h0,                1, 1, 0, 1, 0, 0, 64'h08,               0));
        tbl.push_back(mk(9,  64'h3C,                64'h77,               1, 1, 1, 1, 0, 1, 64'h77,               0));
        tbl.push_back(mk(9,  64'h0,                 64'h0,                1, 1, 0, 1, 0, 0, 64'h3C,               0));
        tbl.push_back(mk(9,  64'h0,                 64'hABCD,             0, 1, 0, 1, 0, 0, 64'hABCD,             0));
        tbl.push_back(mk(10, 64'h8877665544332211,  64'h99,               1, 1, 1, 0, 1, 1, 64'h99,               7));
        tbl.push_back(mk(10, 64'h0,                 64'h0,                1, 1, 0, 0, 1, 0, 64'h8877665544332211, 7));
        tbl.push_back(mk(3,  64'h0,                 64'h42,               1, 0, 0, 0, 1, 1, 64'h42,               0));

        for (int i = 0; i < tbl.size(); i++) begin
            sendOp(tbl[i]);
            idle(1);
        end

        // Outputs hold while no op arrives.
        idle(3);
        chk("hold_valid", 64'(valid_o), 64'd0);
        chk("hold_result", result_o, 64'h42);
        chk("hold_enReg", 64'(enableReg_o), 64'd1);

        // Back-to-back: the store is presented in the cycle the vector load's valid_o is high.
        sendOp(mk(62, 64'h0, 64'h0, 1, 1, 0, 0, 1, 1, 64'h0807060504030201, 7));
        sendOp(mk(30, 64'h5A, 64'h31, 1, 0, 1, 0, 0, 0, 64'h31, 0));
        idle(1);
        sendOp(mk(30, 64'h0, 64'h0, 1, 1, 0, 1, 0, 0, 64'h5A, 0));
        idle(1);
        sendOp(mk(62, 64'h0, 64'h0, 1, 1, 0, 1, 0, 0, 64'h01, 0));
        idle(1);

        // Reset while a vector store is at element 3.
        for (int i = 0; i < 8; i++) begin
            sendOp(mk(6'(20 + i), 64'(8'hE0 + i), 64'h0, 1, 0, 1, 0, 0, 0, 64'h0, 0));
            idle(1);
        end
        idle(2);
        chk("pre_reset_sb_empty", 64'(sb.size()), 64'd0);
        applyOp(mk(20, 64'h1716151413121110, 64'h0, 1, 0, 1, 0, 1, 0, 64'h0, 0));
        #1;
        chk("vec_stall_start", 64'(stall_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("vec_stall_mid", 64'(stall_o), 64'd1);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_stall", 64'(stall_o), 64'd0);
        chk("midrst_flags", {61'd0, writeResultInt_o, writeResultV_o, enableReg_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst_stall", 64'(stall_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            logic [63:0] expv;
            expv = (i < 3) ? 64'(8'h10 + i) : 64'(8'hE0 + i);
            sendOp(mk(6'(20 + i), 64'h0, 64'h0, 1, 1, 0, 1, 0, 0, expv, 0));
            idle(1);
        end

        idle(3);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
